// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  // Memory mask encodings (mt_*) and access direction (me_*)
  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  localparam logic ME_RD = 1'b0;
  localparam logic ME_WR = 1'b1;

  localparam int ARB_TIMEOUT_DEFAULT = 255;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT_RESP,
    ARB_DELIVER
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
    logic [2:0]            mask;
    logic                  wr;
  } ArbReq;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way picker: round-robin against the last owner, or
// fixed priority to index 0 when rr_en is low.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    idx   = 1'b0;
    if (req == 2'b11) begin
      idx = rr_en ? ~last : 1'b0;
    end else if (req == 2'b10) begin
      idx = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core (requester 0) and a debug/DMA
// master (requester 1); one transaction in flight, response watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        rq_notify,
  output logic [1:0]        rq_sync,
  input  logic [ADDR_W-1:0] rq_addr0,
  input  logic [ADDR_W-1:0] rq_addr1,
  input  logic [DATA_W-1:0] rq_data0,
  input  logic [DATA_W-1:0] rq_data1,
  input  logic [2:0]        rq_mask0,
  input  logic [2:0]        rq_mask1,
  input  logic [1:0]        rq_wr,
  output logic [1:0]        rs_notify,
  input  logic [1:0]        rs_sync,
  output logic [DATA_W-1:0] rs_data,
  output logic              rs_err,
  output logic              mem_req_notify,
  input  logic              mem_req_sync,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [2:0]        mem_mask,
  output logic              mem_wr,
  output logic              mem_resp_notify,
  input  logic              mem_resp_sync,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              grant
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [2:0]        mask;
    logic              wr;
  } arb_req_t;

  // Last watchdog value before the timeout fires
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  arb_state_t        state_q;
  arb_req_t          req_q;
  arb_req_t          req0, req1;
  logic              grant_q, last_q;
  logic [1:0]        rq_sync_q, rs_notify_q;
  logic [DATA_W-1:0] rs_data_q;
  logic              rs_err_q;
  logic              mem_req_notify_q, mem_resp_notify_q;
  logic [7:0]        wdog_q, wdog_d;
  logic              pick_valid, pick_idx;

  assign req0 = '{addr: rq_addr0, data: rq_data0, mask: rq_mask0, wr: rq_wr[0]};
  assign req1 = '{addr: rq_addr1, data: rq_data1, mask: rq_mask1, wr: rq_wr[1]};

  assign wdog_d = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;

  rr_pick2 u_pick (
    .req   (rq_notify),
    .last  (last_q),
    .rr_en (RR_EN != 0),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ARB_IDLE;
      req_q             <= '{addr: '0, data: '0, mask: MT_W, wr: ME_RD};
      grant_q           <= 1'b0;
      last_q            <= 1'b1;
      rq_sync_q         <= '0;
      rs_notify_q       <= '0;
      rs_data_q         <= '0;
      rs_err_q          <= 1'b0;
      mem_req_notify_q  <= 1'b0;
      mem_resp_notify_q <= 1'b0;
      wdog_q            <= '0;
    end else begin
      rq_sync_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            req_q            <= pick_idx ? req1 : req0;
            grant_q          <= pick_idx;
            last_q           <= pick_idx;
            mem_req_notify_q <= 1'b1;
            state_q          <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_req_sync) begin
            mem_req_notify_q   <= 1'b0;
            rq_sync_q[grant_q] <= 1'b1;
            mem_resp_notify_q  <= 1'b1;
            wdog_q             <= '0;
            state_q            <= ARB_WAIT_RESP;
          end
        end
        ARB_WAIT_RESP: begin
          wdog_q <= wdog_d;
          // A response arriving on the timeout cycle still wins
          if (mem_resp_sync) begin
            rs_data_q            <= mem_resp_data;
            rs_err_q             <= 1'b0;
            mem_resp_notify_q    <= 1'b0;
            rs_notify_q[grant_q] <= 1'b1;
            state_q              <= ARB_DELIVER;
          end else if (wdog_q >= TO_LAST) begin
            rs_data_q            <= '0;
            rs_err_q             <= 1'b1;
            mem_resp_notify_q    <= 1'b0;
            rs_notify_q[grant_q] <= 1'b1;
            state_q              <= ARB_DELIVER;
          end
        end
        ARB_DELIVER: begin
          if (rs_sync[grant_q]) begin
            rs_notify_q <= '0;
            rs_err_q    <= 1'b0;
            state_q     <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign rq_sync         = rq_sync_q;
  assign rs_notify       = rs_notify_q;
  assign rs_data         = rs_data_q;
  assign rs_err          = rs_err_q;
  assign mem_req_notify  = mem_req_notify_q;
  assign mem_addr        = req_q.addr;
  assign mem_data        = req_q.data;
  assign mem_mask        = req_q.mask;
  assign mem_wr          = req_q.wr;
  assign mem_resp_notify = mem_resp_notify_q;
  assign grant           = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a round-robin and a fixed-priority
// instance share one stimulus stream.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mask;
    logic        wr;
  } req_exp_t;

  typedef struct packed {
    logic        idx;
    logic [31:0] data;
    logic        err;
  } rsp_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rq_notify, rq_wr, rs_sync;
  logic [31:0] rq_addr0, rq_addr1, rq_data0, rq_data1, mem_resp_data;
  logic [2:0]  rq_mask0, rq_mask1;
  logic        mem_req_sync, mem_resp_sync;

  logic [1:0]  a_rq_sync, a_rs_notify, b_rq_sync, b_rs_notify;
  logic [31:0] a_rs_data, a_mem_addr, a_mem_data, b_rs_data, b_mem_addr, b_mem_data;
  logic [2:0]  a_mem_mask, b_mem_mask;
  logic        a_rs_err, a_mem_req_notify, a_mem_wr, a_mem_resp_notify, a_grant;
  logic        b_rs_err, b_mem_req_notify, b_mem_wr, b_mem_resp_notify, b_grant;

  req_exp_t req_q_a[$];
  rsp_exp_t rsp_q_a[$];
  rsp_exp_t rsp_q_b[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .rq_notify(rq_notify), .rq_sync(a_rq_sync),
    .rq_addr0(rq_addr0), .rq_addr1(rq_addr1), .rq_data0(rq_data0), .rq_data1(rq_data1),
    .rq_mask0(rq_mask0), .rq_mask1(rq_mask1), .rq_wr(rq_wr),
    .rs_notify(a_rs_notify), .rs_sync(rs_sync), .rs_data(a_rs_data), .rs_err(a_rs_err),
    .mem_req_notify(a_mem_req_notify), .mem_req_sync(mem_req_sync),
    .mem_addr(a_mem_addr), .mem_data(a_mem_data), .mem_mask(a_mem_mask), .mem_wr(a_mem_wr),
    .mem_resp_notify(a_mem_resp_notify), .mem_resp_sync(mem_resp_sync),
    .mem_resp_data(mem_resp_data), .grant(a_grant)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .rq_notify(rq_notify), .rq_sync(b_rq_sync),
    .rq_addr0(rq_addr0), .rq_addr1(rq_addr1), .rq_data0(rq_data0), .rq_data1(rq_data1),
    .rq_mask0(rq_mask0), .rq_mask1(rq_mask1), .rq_wr(rq_wr),
    .rs_notify(b_rs_notify), .rs_sync(rs_sync), .rs_data(b_rs_data), .rs_err(b_rs_err),
    .mem_req_notify(b_mem_req_notify), .mem_req_sync(mem_req_sync),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_mask(b_mem_mask), .mem_wr(b_mem_wr),
    .mem_resp_notify(b_mem_resp_notify), .mem_resp_sync(mem_resp_sync),
    .mem_resp_data(mem_resp_data), .grant(b_grant)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on every completed handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (a_mem_req_notify && mem_req_sync) begin
        if (req_q_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_mem_req: unexpected request addr 0x%0h", a_mem_addr);
        end else begin
          req_exp_t e;
          e = req_q_a.pop_front();
          chk("a_mem_addr", a_mem_addr, e.addr);
          chk("a_mem_data", a_mem_data, e.data);
          chk("a_mem_mask_wr", {a_mem_mask, a_mem_wr}, {e.mask, e.wr});
        end
      end
      if ((a_rs_notify & rs_sync) != 2'b00) begin
        if (rsp_q_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_rsp: unexpected response rs_notify=%b", a_rs_notify);
        end else begin
          rsp_exp_t e;
          e = rsp_q_a.pop_front();
          chk("a_rsp_idx", a_rs_notify, e.idx ? 2'b10 : 2'b01);
          chk("a_rsp_data", a_rs_data, e.data);
          chk("a_rsp_err", a_rs_err, e.err);
        end
      end
      if ((b_rs_notify & rs_sync) != 2'b00) begin
        if (rsp_q_b.size() == 0) begin
          n_checks++;
          $display("FAIL b_rsp: unexpected response rs_notify=%b", b_rs_notify);
        end else begin
          rsp_exp_t e;
          e = rsp_q_b.pop_front();
          chk("b_rsp_idx", b_rs_notify, e.idx ? 2'b10 : 2'b01);
          chk("b_rsp_data", b_rs_data, e.data);
          chk("b_rsp_err", b_rs_err, e.err);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rq_notify = '0; rq_wr = '0; rs_sync = '0;
    rq_addr0 = '0; rq_addr1 = '0; rq_data0 = '0; rq_data1 = '0;
    rq_mask0 = MT_W; rq_mask1 = MT_W;
    mem_req_sync = 1'b1; mem_resp_sync = 1'b1; mem_resp_data = '0;
    repeat (2) step();

    chk("rst_ctrl", {a_rq_sync, a_rs_notify, a_rs_err, a_mem_req_notify, a_mem_resp_notify, a_grant}, 0);
    chk("rst_data", {a_mem_addr, a_mem_data, a_rs_data}, 0);
    chk("rst_mask_wr", {a_mem_mask, a_mem_wr}, {MT_W, ME_RD});
    rst = 1'b0;
    step();

    // Tie held for four transactions: RR gives 0,1,0,1, fixed gives 0,0,0,0
    rq_notify = 2'b11; rq_addr0 = 32'h10; rq_addr1 = 32'h20;
    rq_data0 = 32'h11; rq_data1 = 32'h22; rs_sync = 2'b11; mem_resp_data = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      req_q_a.push_back(req_exp_t'{(i % 2 == 0) ? 32'h10 : 32'h20, (i % 2 == 0) ? 32'h11 : 32'h22, MT_W, 1'b0});
      rsp_q_a.push_back(rsp_exp_t'{(i % 2 == 1), 32'h0BADF00D, 1'b0});
      rsp_q_b.push_back(rsp_exp_t'{1'b0, 32'h0BADF00D, 1'b0});
    end
    repeat (14) step();
    rq_notify = 2'b00;
    repeat (3) step();

    // Single read from requester 0
    rq_notify = 2'b01; rq_addr0 = 32'h100; rq_data0 = '0; rq_wr = 2'b00;
    mem_resp_data = 32'hDEADBEEF; rs_sync = 2'b01;
    req_q_a.push_back(req_exp_t'{32'h100, 32'h0, MT_W, 1'b0});
    rsp_q_a.push_back(rsp_exp_t'{1'b0, 32'hDEADBEEF, 1'b0});
    rsp_q_b.push_back(rsp_exp_t'{1'b0, 32'hDEADBEEF, 1'b0});
    chk("t1_no_req_at_N", a_mem_req_notify, 1'b0);
    step();
    chk("t1_req_at_N1", a_mem_req_notify, 1'b1);
    chk("t1_addr_wr", {a_mem_addr, a_mem_wr}, {32'h100, ME_RD});
    step();
    chk("t1_rq_sync", a_rq_sync, 2'b01);
    rq_notify = 2'b00;
    step();
    chk("t1_rq_sync_pulse", a_rq_sync, 2'b00);
    chk("t1_rs_notify", a_rs_notify, 2'b01);
    step();
    chk("t1_back_idle", a_rs_notify, 2'b00);

    // Write from requester 1 with 5 stall cycles on the request
    mem_req_sync = 1'b0;
    rq_notify = 2'b10; rq_addr1 = 32'h2000; rq_data1 = 32'h12345678;
    rq_mask1 = MT_H; rq_wr = 2'b10; mem_resp_data = 32'hCAFE0001; rs_sync = 2'b10;
    req_q_a.push_back(req_exp_t'{32'h2000, 32'h12345678, MT_H, 1'b1});
    rsp_q_a.push_back(rsp_exp_t'{1'b1, 32'hCAFE0001, 1'b0});
    rsp_q_b.push_back(rsp_exp_t'{1'b1, 32'hCAFE0001, 1'b0});
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_req_stable", {a_mem_req_notify, a_mem_addr, a_mem_data, a_mem_mask, a_mem_wr},
          {1'b1, 32'h2000, 32'h12345678, MT_H, ME_WR});
      step();
    end
    mem_req_sync = 1'b1;
    step();
    chk("t3_rq_sync", a_rq_sync, 2'b10);
    rq_notify = 2'b00; rq_wr = 2'b00; rq_mask1 = MT_W;
    repeat (2) step();

    // Timeout: memory never answers
    mem_resp_sync = 1'b0;
    rq_notify = 2'b01; rq_addr0 = 32'h300; mem_resp_data = 32'h55555555; rs_sync = 2'b01;
    req_q_a.push_back(req_exp_t'{32'h300, 32'h0, MT_W, 1'b0});
    rsp_q_a.push_back(rsp_exp_t'{1'b0, 32'h0, 1'b1});
    rsp_q_b.push_back(rsp_exp_t'{1'b0, 32'h0, 1'b1});
    repeat (2) step();
    rq_notify = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_early_rsp", a_rs_notify, 2'b00);
      step();
    end
    chk("t4_timeout_rsp", {a_rs_notify, a_rs_err, a_rs_data}, {2'b01, 1'b1, 32'h0});
    step();

    // Response lands on the timeout cycle
    rq_notify = 2'b01; mem_resp_data = 32'h77777777;
    req_q_a.push_back(req_exp_t'{32'h300, 32'h0, MT_W, 1'b0});
    rsp_q_a.push_back(rsp_exp_t'{1'b0, 32'h77777777, 1'b0});
    rsp_q_b.push_back(rsp_exp_t'{1'b0, 32'h77777777, 1'b0});
    repeat (2) step();
    rq_notify = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("t4b_no_early_rsp", a_rs_notify, 2'b00);
      if (i == 3) mem_resp_sync = 1'b1;
      step();
    end
    chk("t4b_late_rsp_wins", {a_rs_notify, a_rs_err, a_rs_data}, {2'b01, 1'b0, 32'h77777777});
    step();

    // Response back-pressure with a pending request from requester 1
    rs_sync = 2'b00; rq_notify = 2'b01; rq_addr0 = 32'h400; mem_resp_data = 32'h44440000;
    rq_addr1 = 32'h500; rq_data1 = 32'h5;
    req_q_a.push_back(req_exp_t'{32'h400, 32'h0, MT_W, 1'b0});
    req_q_a.push_back(req_exp_t'{32'h500, 32'h5, MT_W, 1'b0});
    rsp_q_a.push_back(rsp_exp_t'{1'b0, 32'h44440000, 1'b0});
    rsp_q_a.push_back(rsp_exp_t'{1'b1, 32'h55550000, 1'b0});
    rsp_q_b.push_back(rsp_exp_t'{1'b0, 32'h44440000, 1'b0});
    rsp_q_b.push_back(rsp_exp_t'{1'b1, 32'h55550000, 1'b0});
    repeat (2) step();
    rq_notify = 2'b00;
    step();
    rq_notify = 2'b10;
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold", {a_rs_notify, a_rs_data, a_rs_err, a_mem_req_notify},
          {2'b01, 32'h44440000, 1'b0, 1'b0});
      step();
    end
    rs_sync = 2'b01;
    step();
    rs_sync = 2'b10; mem_resp_data = 32'h55550000;
    step();
    chk("t5_second_grant", {a_mem_req_notify, a_grant}, 2'b11);
    step();
    rq_notify = 2'b00;
    repeat (2) step();

    // Asynchronous reset while waiting for the memory response
    mem_resp_sync = 1'b0; rq_notify = 2'b10; rq_addr1 = 32'h600;
    req_q_a.push_back(req_exp_t'{32'h600, 32'h5, MT_W, 1'b0});
    repeat (2) step();
    rq_notify = 2'b00;
    step();
    chk("t6_in_wait", {a_mem_resp_notify, a_grant}, 2'b11);
    rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", {a_rq_sync, a_rs_notify, a_rs_err, a_mem_req_notify, a_mem_resp_notify, a_grant}, 0);
    chk("t6_rst_data", {a_mem_addr, a_mem_data, a_rs_data, a_mem_mask, a_mem_wr}, {96'h0, MT_W, ME_RD});
    chk("t6_rst_b", {b_rq_sync, b_rs_notify, b_rs_err, b_mem_req_notify, b_mem_resp_notify, b_grant,
                     b_mem_addr, b_mem_data, b_rs_data, b_mem_mask, b_mem_wr},
        {8'h0, 96'h0, MT_W, ME_RD});
    step();
    rst = 1'b0; mem_resp_sync = 1'b1;
    rq_notify = 2'b11; rq_addr0 = 32'h700; rq_addr1 = 32'h800; rq_data0 = 32'h0;
    rs_sync = 2'b11; mem_resp_data = 32'h66;
    req_q_a.push_back(req_exp_t'{32'h700, 32'h0, MT_W, 1'b0});
    rsp_q_a.push_back(rsp_exp_t'{1'b0, 32'h66, 1'b0});
    rsp_q_b.push_back(rsp_exp_t'{1'b0, 32'h66, 1'b0});
    step();
    chk("t6_tie_after_rst", {a_grant, b_grant}, 2'b00);
    step();
    rq_notify = 2'b00;

    for (int i = 0; i < 20 && (req_q_a.size() + rsp_q_a.size() + rsp_q_b.size()) > 0; i++) step();
    chk("queues_drained", req_q_a.size() + rsp_q_a.size() + rsp_q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
